img_frame_ctrl: RTL and testbench

- Frame-level sequencer for the pixel-processing datapath (invert, grayscale, 3x3 edge, 3x3 blur).
- On a start pulse, latches the op select and raster-scans the frame.
- Issues source-pixel reads, supplies window and border qualifiers, and issues result writes delayed by the datapath latency.
- Supports a global stall and pulses ctrl_done after the last write.

---
 rtl/img_frame_ctrl_if.sv | 37 +++
 rtl/img_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_img_frame_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/img_frame_ctrl_if.sv
// Control/bus bundle between the frame sequencer and the pixel datapath.
//   start/sel/stall     : frame request, op select, global stall (into the sequencer)
//   op_sel/busy/ce      : latched op, frame-active flag, datapath clock enable
//   rd_en/rd_addr       : source pixel read strobe and index
//   ctr_valid           : window centre valid at issue time
//   wr_en/wr_addr/wr_border : result write strobe, index, border qualifier
//   ctrl_done           : one-cycle end-of-frame pulse
// The sequencer drives through the master modport; the datapath/bench side uses slave.
interface img_frame_ctrl_if #(
  parameter int ADDR_W = 19
) ();
  logic              start;
  logic [1:0]        sel;
  logic              stall;
  logic [1:0]        op_sel;
  logic              busy;
  logic              ce;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ctr_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_border;
  logic              ctrl_done;

  modport master (
    input  start, sel, stall,
    output op_sel, busy, ce, rd_en, rd_addr, ctr_valid,
           wr_en, wr_addr, wr_border, ctrl_done
  );

  modport slave (
    output start, sel, stall,
    input  op_sel, busy, ce, rd_en, rd_addr, ctr_valid,
           wr_en, wr_addr, wr_border, ctrl_done
  );
endinterface

// File: rtl/img_frame_ctrl.sv
// Frame-level sequencer for the pixel datapath (edge / invert / grayscale / blur).
// On an accepted start it latches the op, raster-scans WIDTH x HEIGHT source
// pixels, tracks the window centre (lagging the read by WIDTH+1 for 3x3 kernel
// ops), and replays {valid, centre, border} through a PIPE_LAT-deep delay pipe
// so result writes line up with the datapath latency.
// Ports:
//   HCLK   : clock, rising edge
//   HRESET : synchronous reset, active high (aborts a frame, no ctrl_done)
//   bus    : img_frame_ctrl_if.master (see interface header for signal list)
module img_frame_ctrl #(
  parameter int WIDTH    = 768,
  parameter int HEIGHT   = 512,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = 19
) (
  input  logic               HCLK,
  input  logic               HRESET,
  img_frame_ctrl_if.master   bus
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N + WIDTH + 2);
  localparam int RW = $clog2(HEIGHT);
  localparam int LW = $clog2(WIDTH);
  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [CW-1:0] K_C      = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [LW-1:0] COL_LAST = LW'(WIDTH - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]                      op_sel;
  logic [CW-1:0]                   s, k_val, s_last;
  logic [ADDR_W-1:0]               caddr;
  logic [RW-1:0]                   crow;
  logic [LW-1:0]                   ccol;
  logic [DW-1:0]                   dcnt;
  logic [PIPE_LAT-1:0]             vld_pipe, bdr_pipe;
  logic [PIPE_LAT-1:0][ADDR_W-1:0] adr_pipe;
  logic kern, busy, ce, run_en, ctr_ok, border, accept;

  // Kernel ops need a full line plus one pixel of look-ahead before the
  // first centre is complete, so the step count grows by WIDTH+1.
  assign kern   = (op_sel == 2'b00) || (op_sel == 2'b11);
  assign k_val  = kern ? K_C : '0;
  assign s_last = N_C + k_val - CW'(1);

  assign busy   = (state != IDLE);
  assign ce     = busy & ~bus.stall & (state != DONE);
  assign run_en = (state == RUN) & ~bus.stall;
  assign ctr_ok = (state == RUN) && (s >= k_val);
  assign border = kern && (crow == '0 || crow == ROW_LAST ||
                           ccol == '0 || ccol == COL_LAST);
  assign accept = (state == IDLE) & bus.start;

  // FSM state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (run_en && s == s_last) state_nx = DRAIN;
      DRAIN:   if (ce && dcnt == D_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Step / centre counters and delay pipe
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      op_sel   <= '0;
      s        <= '0;
      caddr    <= '0;
      crow     <= '0;
      ccol     <= '0;
      dcnt     <= '0;
      vld_pipe <= '0;
      bdr_pipe <= '0;
      adr_pipe <= '0;
    end else begin
      if (accept) begin
        op_sel <= bus.sel;
        s      <= '0;
        caddr  <= '0;
        crow   <= '0;
        ccol   <= '0;
        dcnt   <= '0;
      end
      if (run_en) begin
        s <= s + CW'(1);
        // centre row/col advance only once the centre is valid; wrap by compare
        if (ctr_ok) begin
          caddr <= caddr + ADDR_W'(1);
          if (ccol == COL_LAST) begin
            ccol <= '0;
            crow <= crow + RW'(1);
          end else begin
            ccol <= ccol + LW'(1);
          end
        end
      end
      if (state == DRAIN && ce) dcnt <= dcnt + DW'(1);
      // Invalid slots are pushed as all-zero so the outputs idle at 0.
      if (ce) begin
        for (int i = PIPE_LAT - 1; i > 0; i--) begin
          vld_pipe[i] <= vld_pipe[i-1];
          bdr_pipe[i] <= bdr_pipe[i-1];
          adr_pipe[i] <= adr_pipe[i-1];
        end
        vld_pipe[0] <= ctr_ok;
        bdr_pipe[0] <= ctr_ok & border;
        adr_pipe[0] <= ctr_ok ? caddr : '0;
      end
    end
  end

  assign bus.op_sel    = op_sel;
  assign bus.busy      = busy;
  assign bus.ce        = ce;
  assign bus.rd_en     = run_en && (s < N_C);
  assign bus.rd_addr   = ((state == RUN) && (s < N_C)) ? ADDR_W'(s) : '0;
  assign bus.ctr_valid = ctr_ok & ~bus.stall;
  assign bus.wr_en     = vld_pipe[PIPE_LAT-1] & ce;
  assign bus.wr_addr   = adr_pipe[PIPE_LAT-1];
  assign bus.wr_border = bdr_pipe[PIPE_LAT-1];
  assign bus.ctrl_done = (state == DONE);

endmodule

// File: tb/tb_img_frame_ctrl.sv
// Bench for img_frame_ctrl (4x3 frame, latency 2): directed test-plan
// sequences followed by randomized start/sel/stall/reset traffic, all checked
// cycle by cycle against a frame-level model counting enabled cycles.
module tb_img_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 2;
  localparam int AW = 4;
  localparam int N  = W * H;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  img_frame_ctrl_if #(.ADDR_W(AW)) bus ();

  img_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(L), .ADDR_W(AW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  // frame model: ph 0 idle, 1 active (enabled-cycle counter e), 2 done cycle
  int         ph = 0;
  int         e = 0;
  int         kk = 0;
  int         ss = 0;
  int         wr_cnt = 0;
  logic [1:0] mop = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic st, input logic [1:0] sl, input logic stl,
                      input logic rs, output logic done_seen);
    logic en, x_rd, x_cv, x_wr, x_b;
    int   wa;
    @(negedge HCLK);
    bus.start = st;
    bus.sel   = sl;
    bus.stall = stl;
    HRESET    = rs;
    #1;
    en   = (ph == 1) && !stl;
    x_rd = en && (e < N);
    x_cv = en && (e >= kk) && (e < ss);
    x_wr = en && (e >= kk + L) && (e < ss + L);
    wa   = e - kk - L;
    x_b  = x_wr && (kk != 0) &&
           (wa / W == 0 || wa / W == H - 1 || wa % W == 0 || wa % W == W - 1);
    if (chk_on) begin
      chk("busy",      bus.busy,      ph != 0);
      chk("ctrl_done", bus.ctrl_done, ph == 2);
      chk("ce",        bus.ce,        en);
      chk("rd_en",     bus.rd_en,     x_rd);
      chk("ctr_valid", bus.ctr_valid, x_cv);
      chk("wr_en",     bus.wr_en,     x_wr);
      chk("op_sel",    bus.op_sel,    mop);
      if (x_rd) chk("rd_addr", bus.rd_addr, e);
      if (x_wr) begin
        chk("wr_addr",   bus.wr_addr,   wa);
        chk("wr_border", bus.wr_border, x_b);
      end
      if (ph == 0) begin
        chk("idle_rd_addr",   bus.rd_addr,   0);
        chk("idle_wr_addr",   bus.wr_addr,   0);
        chk("idle_wr_border", bus.wr_border, 0);
      end
    end
    if (bus.wr_en) wr_cnt++;
    done_seen = bus.ctrl_done;
    // model update for the coming clock edge
    if (rs) begin
      ph  = 0;
      e   = 0;
      mop = 2'b00;
    end else begin
      case (ph)
        0: if (st) begin
          ph     = 1;
          e      = 0;
          mop    = sl;
          kk     = (sl == 2'b00 || sl == 2'b11) ? W + 1 : 0;
          ss     = N + kk;
          wr_cnt = 0;
        end
        1: if (!stl) begin
          e++;
          if (e == ss + L) ph = 2;
        end
        default: begin
          if (chk_on) chk("frame_writes", wr_cnt, N);
          ph = 0;
        end
      endcase
    end
  endtask

  // relative cycle 0 carries the start; sel is randomized on every other cycle
  task automatic run_seq(input string nm, input logic [1:0] sl, input logic [63:0] st_m,
                         input logic [63:0] stl_m, input logic [63:0] rs_m,
                         input int ncyc, input int exp_done);
    int first_done;
    first_done = -1;
    for (int i = 0; i < ncyc; i++) begin
      logic       d;
      logic [1:0] sv;
      sv = (i == 0) ? sl : 2'($urandom);
      tick(st_m[i], sv, stl_m[i], rs_m[i], d);
      if (d && first_done < 0) first_done = i;
    end
    chk(nm, first_done, exp_done);
  endtask

  initial begin
    logic d;
    bus.start = 1'b0;
    bus.sel   = 2'b00;
    bus.stall = 1'b0;
    repeat (2) tick(1'b0, 2'b00, 1'b0, 1'b1, d);
    chk_on = 1'b1;
    repeat (2) tick(1'b0, 2'b00, 1'b0, 1'b0, d);

    run_seq("s1_invert_done", 2'b01, 64'h1,     64'h0,     64'h0,  17, 15);
    run_seq("s2_edge_done",   2'b00, 64'h1,     64'h0,     64'h0,  22, 20);
    run_seq("s3_stall_done",  2'b10, 64'h1,     64'h30,    64'h0,  19, 17);
    run_seq("s4_restart_done",2'b01, 64'h18021, 64'h0,     64'h0,  40, 15);
    run_seq("s5_reset_nodone",2'b11, 64'h1,     64'h0,     64'h80, 12, -1);
    run_seq("s6_drain_stall", 2'b11, 64'h1,     64'h40000, 64'h0,  24, 21);

    for (int i = 0; i < 2500; i++) begin
      tick($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 299) == 0, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
